// File: rtl/countdown_timer.sv
// countdown_timer: preset MM:SS countdown in 10 ms steps, shown as MM:SS.cc.
// Three active-low keys (start/pause, set, inc) are synchronised and debounced
// internally; the count uses a BCD borrow chain and drives six common-anode
// seven-segment digits (gfedcba, 0 = lit).
module countdown_timer #(
   parameter int TICK_DIV = 500000,
   parameter int DEBOUNCE = 1000000
) (
   input  logic       clk,
   input  logic       key_reset,
   input  logic       key_start_pause,
   input  logic       key_set,
   input  logic       key_inc,
   output logic [6:0] hex5,
   output logic [6:0] hex4,
   output logic [6:0] hex3,
   output logic [6:0] hex2,
   output logic [6:0] hex1,
   output logic [6:0] hex0,
   output logic       led0,
   output logic       led1,
   output logic       led2,
   output logic       led3
);

   localparam int PS_W = $clog2(TICK_DIV + 1);
   localparam int DB_W = $clog2(DEBOUNCE + 1);
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SET     = 3'd1,
      ST_RUN     = 3'd2,
      ST_PAUSE   = 3'd3,
      ST_EXPIRED = 3'd4
   } state_t;

   // Key index: 0 = start/pause, 1 = set, 2 = inc
   logic [2:0] key_raw;
   logic [2:0] key_event;
   logic       ev_start;
   logic       ev_set;
   logic       ev_inc;

   assign key_raw = {key_inc, key_set, key_start_pause};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_key
         logic            sync1_reg;
         logic            sync2_reg;
         logic            fired_reg;
         logic [DB_W-1:0] cnt_reg;

         // Synchronise the key, count consecutive low cycles, fire once per press
         always_ff @(posedge clk or negedge key_reset) begin
            if (!key_reset) begin
               sync1_reg <= 1'b1;
               sync2_reg <= 1'b1;
               fired_reg <= 1'b0;
               cnt_reg   <= '0;
            end else begin
               sync1_reg <= key_raw[gi];
               sync2_reg <= sync1_reg;
               if (sync2_reg) begin
                  // Released: re-arm for the next press
                  cnt_reg   <= '0;
                  fired_reg <= 1'b0;
               end else if (key_event[gi]) begin
                  fired_reg <= 1'b1;
               end else if (!fired_reg) begin
                  cnt_reg <= cnt_reg + DB_W'(1);
               end
            end
         end

         assign key_event[gi] = ~sync2_reg & ~fired_reg & (cnt_reg == DB_LAST);
      end
   endgenerate

   // Coincident events: start beats set beats inc; the losers are discarded
   assign ev_start = key_event[0];
   assign ev_set   = key_event[1] & ~key_event[0];
   assign ev_inc   = key_event[2] & ~key_event[1] & ~key_event[0];

   // Digit order: count 0=cc units,1=cc tens,2=ss units,3=ss tens,4=mm units,5=mm tens
   //              preset 0=ss units,1=ss tens,2=mm units,3=mm tens
   state_t          state_reg;
   logic            field_reg;          // 0 = minutes, 1 = seconds
   logic [3:0]      preset_reg [4];
   logic [3:0]      count_reg  [6];
   logic [PS_W-1:0] presc_reg;
   logic [3:0]      led_reg;

   logic [3:0]      count_dec  [6];
   logic [3:0]      count_load [6];
   logic            dec_zero;
   logic            preset_nz;
   logic [7:0]      min_inc;
   logic [7:0]      sec_inc;
   logic            borrow;

   // Increment a two-digit BCD field, wrapping 59 back to 00
   function automatic logic [7:0] bcd_inc59(input logic [3:0] tens, input logic [3:0] units);
      if (units == 4'd9) begin
         if (tens == 4'd5) begin
            return 8'h00;
         end
         return {tens + 4'd1, 4'd0};
      end
      return {tens, units + 4'd1};
   endfunction

   // Common-anode decode; anything outside 0..9 is blanked
   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b100_0000;
         4'd1:    return 7'b111_1001;
         4'd2:    return 7'b010_0100;
         4'd3:    return 7'b011_0000;
         4'd4:    return 7'b001_1001;
         4'd5:    return 7'b001_0010;
         4'd6:    return 7'b000_0010;
         4'd7:    return 7'b111_1000;
         4'd8:    return 7'b000_0000;
         4'd9:    return 7'b001_0000;
         default: return 7'b111_1111;
      endcase
   endfunction

   // Count minus 0.01 s with BCD borrow; seconds tens borrow from 0 to 5, others to 9
   always_comb begin
      borrow   = 1'b1;
      dec_zero = 1'b1;
      for (int i = 0; i < 6; i++) begin
         count_dec[i] = count_reg[i];
         if (borrow) begin
            if (count_reg[i] == 4'd0) begin
               count_dec[i] = (i == 3) ? 4'd5 : 4'd9;
            end else begin
               count_dec[i] = count_reg[i] - 4'd1;
               borrow       = 1'b0;
            end
         end
         dec_zero = dec_zero & (count_dec[i] == 4'd0);
      end
   end

   // Preset expanded to a full count value with centiseconds zero, plus field increments
   always_comb begin
      count_load[0] = 4'd0;
      count_load[1] = 4'd0;
      count_load[2] = preset_reg[0];
      count_load[3] = preset_reg[1];
      count_load[4] = preset_reg[2];
      count_load[5] = preset_reg[3];
      preset_nz     = (preset_reg[0] != 4'd0) | (preset_reg[1] != 4'd0) |
                      (preset_reg[2] != 4'd0) | (preset_reg[3] != 4'd0);
      min_inc       = bcd_inc59(preset_reg[3], preset_reg[2]);
      sec_inc       = bcd_inc59(preset_reg[1], preset_reg[0]);
   end

   // Main state machine; the LED register is updated alongside every state change
   always_ff @(posedge clk or negedge key_reset) begin
      if (!key_reset) begin
         state_reg <= ST_IDLE;
         field_reg <= 1'b0;
         presc_reg <= '0;
         led_reg   <= 4'b0000;
         for (int i = 0; i < 4; i++) preset_reg[i] <= 4'd0;
         for (int i = 0; i < 6; i++) count_reg[i] <= 4'd0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (ev_start) begin
                  if (preset_nz) begin
                     state_reg <= ST_RUN;
                     led_reg   <= 4'b0001;
                  end
               end else if (ev_set) begin
                  state_reg <= ST_SET;
                  field_reg <= 1'b0;
                  led_reg   <= 4'b0100;
               end
            end
            ST_SET: begin
               if (ev_set) begin
                  if (!field_reg) begin
                     field_reg <= 1'b1;
                     led_reg   <= 4'b1000;
                  end else begin
                     state_reg <= ST_IDLE;
                     field_reg <= 1'b0;
                     count_reg <= count_load;
                     presc_reg <= '0;
                     led_reg   <= 4'b0000;
                  end
               end else if (ev_inc) begin
                  if (!field_reg) begin
                     preset_reg[3] <= min_inc[7:4];
                     preset_reg[2] <= min_inc[3:0];
                  end else begin
                     preset_reg[1] <= sec_inc[7:4];
                     preset_reg[0] <= sec_inc[3:0];
                  end
               end
            end
            ST_RUN: begin
               // A start event pre-empts the tick: prescaler and count both hold
               if (ev_start) begin
                  state_reg <= ST_PAUSE;
                  led_reg   <= 4'b0000;
               end else if (presc_reg == PS_LAST) begin
                  presc_reg <= '0;
                  count_reg <= count_dec;
                  if (dec_zero) begin
                     state_reg <= ST_EXPIRED;
                     led_reg   <= 4'b0010;
                  end
               end else begin
                  presc_reg <= presc_reg + PS_W'(1);
               end
            end
            ST_PAUSE: begin
               if (ev_start) begin
                  state_reg <= ST_RUN;
                  led_reg   <= 4'b0001;
               end else if (ev_set) begin
                  state_reg <= ST_IDLE;
                  count_reg <= count_load;
                  presc_reg <= '0;
                  led_reg   <= 4'b0000;
               end
            end
            ST_EXPIRED: begin
               if (ev_start | ev_set) begin
                  state_reg <= ST_IDLE;
                  count_reg <= count_load;
                  presc_reg <= '0;
                  led_reg   <= 4'b0000;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               presc_reg <= '0;
               led_reg   <= 4'b0000;
            end
         endcase
      end
   end

   // SET shows the preset being edited; every other state shows the live count
   logic [3:0] disp [6];
   logic [6:0] seg  [6];

   always_comb begin
      for (int i = 0; i < 6; i++) begin
         disp[i] = (state_reg == ST_SET) ? count_load[i] : count_reg[i];
      end
   end

   generate
      for (genvar gi = 0; gi < 6; gi++) begin : g_seg
         assign seg[gi] = seg7(disp[gi]);
      end
   endgenerate

   assign hex0 = seg[0];
   assign hex1 = seg[1];
   assign hex2 = seg[2];
   assign hex3 = seg[3];
   assign hex4 = seg[4];
   assign hex5 = seg[5];

   assign led0 = led_reg[0];
   assign led1 = led_reg[1];
   assign led2 = led_reg[2];
   assign led3 = led_reg[3];

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer (TICK_DIV=4, DEBOUNCE=3): per-cycle comparison
// against a centisecond-arithmetic reference model, a table of key steps with
// fixed expected displays, and hand sequences for timing corner cases.
module tb_countdown_timer;

   localparam int TD = 4;
   localparam int D  = 3;

   localparam logic [2:0] K_START = 3'b001;
   localparam logic [2:0] K_SET   = 3'b010;
   localparam logic [2:0] K_INC   = 3'b100;

   localparam int S_IDLE = 0, S_SET = 1, S_RUN = 2, S_PAUSE = 3, S_EXP = 4;

   logic       clk = 1'b0;
   logic       key_reset;
   logic       ks, kset, kinc;
   logic [6:0] hex5, hex4, hex3, hex2, hex1, hex0;
   logic       led0, led1, led2, led3;
   logic [45:0] dut_out;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: count kept as total centiseconds
   int         m_state, m_field, m_pre_m, m_pre_s, m_count, m_presc;
   logic [D+1:0] m_hist [3];   // bit0 = pin sample at the previous edge

   countdown_timer #(.TICK_DIV(TD), .DEBOUNCE(D)) dut (
      .clk(clk), .key_reset(key_reset),
      .key_start_pause(ks), .key_set(kset), .key_inc(kinc),
      .hex5(hex5), .hex4(hex4), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
      .led0(led0), .led1(led1), .led2(led2), .led3(led3)
   );

   always #5 clk = ~clk;

   assign dut_out = {hex5, hex4, hex3, hex2, hex1, hex0, led3, led2, led1, led0};

   function automatic logic [6:0] seg_of(input int v);
      case (v)
         0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
         4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
         8: return 7'h00;  9: return 7'h10;
         default: return 7'h7f;
      endcase
   endfunction

   // Expected outputs from six BCD display digits (mm ss cc) and the LED nibble
   function automatic logic [45:0] exp_const(input logic [23:0] d, input logic [3:0] l);
      return {seg_of(int'(d[23:20])), seg_of(int'(d[19:16])), seg_of(int'(d[15:12])),
              seg_of(int'(d[11:8])), seg_of(int'(d[7:4])), seg_of(int'(d[3:0])), l};
   endfunction

   function automatic int pre_total();
      return (m_pre_m * 60 + m_pre_s) * 100;
   endfunction

   function automatic logic [45:0] exp_model();
      int cs, mm, ss, cc;
      logic [3:0] l;
      cs = (m_state == S_SET) ? pre_total() : m_count;
      mm = cs / 6000;
      ss = (cs / 100) % 60;
      cc = cs % 100;
      l  = {m_state == S_SET && m_field == 1, m_state == S_SET && m_field == 0,
            m_state == S_EXP, m_state == S_RUN};
      return {seg_of(mm / 10), seg_of(mm % 10), seg_of(ss / 10), seg_of(ss % 10),
              seg_of(cc / 10), seg_of(cc % 10), l};
   endfunction

   task automatic model_reset();
      m_state = S_IDLE; m_field = 0; m_pre_m = 0; m_pre_s = 0; m_count = 0; m_presc = 0;
      for (int k = 0; k < 3; k++) m_hist[k] = '1;
   endtask

   // One clock edge of the reference model
   task automatic model_step();
      logic [2:0] pins, ev;
      logic es, eset, einc;
      if (!key_reset) begin
         model_reset();
         return;
      end
      pins = {kinc, kset, ks};
      for (int k = 0; k < 3; k++) begin
         // Event: exactly D low samples (seen through 2 sync stages) preceded by a high one
         ev[k] = (m_hist[k][D:1] == '0) && m_hist[k][D+1];
         m_hist[k] = {m_hist[k][D:0], pins[k]};
      end
      es   = ev[0];
      eset = ev[1] && !ev[0];
      einc = ev[2] && !ev[1] && !ev[0];
      case (m_state)
         S_IDLE: begin
            if (es) begin
               if (pre_total() != 0) m_state = S_RUN;
            end else if (eset) begin
               m_state = S_SET; m_field = 0;
            end
         end
         S_SET: begin
            if (eset) begin
               if (m_field == 0) m_field = 1;
               else begin
                  m_state = S_IDLE; m_field = 0; m_count = pre_total(); m_presc = 0;
               end
            end else if (einc) begin
               if (m_field == 0) m_pre_m = (m_pre_m + 1) % 60;
               else              m_pre_s = (m_pre_s + 1) % 60;
            end
         end
         S_RUN: begin
            if (es) m_state = S_PAUSE;
            else if (m_presc == TD - 1) begin
               m_presc = 0;
               m_count = m_count - 1;
               if (m_count == 0) m_state = S_EXP;
            end else m_presc = m_presc + 1;
         end
         S_PAUSE: begin
            if (es) m_state = S_RUN;
            else if (eset) begin
               m_state = S_IDLE; m_count = pre_total(); m_presc = 0;
            end
         end
         default: begin
            if (es || eset) begin
               m_state = S_IDLE; m_count = pre_total(); m_presc = 0;
            end
         end
      endcase
   endtask

   task automatic check(input string name, input logic [45:0] act, input logic [45:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Advance one clock, step the model, compare all outputs 1 time unit later
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check("cycle", dut_out, exp_model());
   endtask

   task automatic press_mask(input logic [2:0] m, input int hold, input int gap);
      ks = ~m[0]; kset = ~m[1]; kinc = ~m[2];
      repeat (hold) tick();
      ks = 1'b1; kset = 1'b1; kinc = 1'b1;
      repeat (gap) tick();
   endtask

   task automatic press(input logic [2:0] m);
      press_mask(m, D + 2, D + 4);
   endtask

   // Asynchronous reset between clock edges, held for two edges
   task automatic do_reset();
      #2;
      key_reset = 1'b0;
      ks = 1'b1; kset = 1'b1; kinc = 1'b1;
      model_reset();
      #1;
      check("async_reset", dut_out, exp_const(24'h000000, 4'b0000));
      repeat (2) tick();
      key_reset = 1'b1;
   endtask

   typedef struct {
      logic [2:0]  mask;
      int          hold;
      logic [23:0] disp;
      logic [3:0]  leds;
   } step_t;

   step_t tbl [8];

   initial begin
      tbl[0] = '{K_SET, 5, 24'h000000, 4'b0100};
      tbl[1] = '{K_INC, 5, 24'h010000, 4'b0100};
      tbl[2] = '{K_INC, 5, 24'h020000, 4'b0100};
      tbl[3] = '{K_SET, 5, 24'h020000, 4'b1000};
      tbl[4] = '{K_INC, 5, 24'h020100, 4'b1000};
      tbl[5] = '{K_INC, 5, 24'h020200, 4'b1000};
      tbl[6] = '{K_INC, 5, 24'h020300, 4'b1000};
      tbl[7] = '{K_SET, 5, 24'h020300, 4'b0000};

      key_reset = 1'b0; ks = 1'b1; kset = 1'b1; kinc = 1'b1;
      model_reset();
      repeat (3) tick();
      check("reset_state", dut_out, exp_const(24'h000000, 4'b0000));
      key_reset = 1'b1;
      repeat (2) tick();

      // Preset entry 02:03 through the step table
      for (int i = 0; i < 8; i++) begin
         press_mask(tbl[i].mask, tbl[i].hold, D + 4);
         $display("step %0d: keys=%b display=%h leds=%b", i, tbl[i].mask, dut_out[45:4], dut_out[3:0]);
         check($sformatf("table_%0d", i), dut_out, exp_const(tbl[i].disp, tbl[i].leds));
      end

      // Preset 00:01 run to expiry
      do_reset();
      tick();
      press(K_SET); press(K_SET); press(K_INC); press(K_SET);
      check("preset_0001", dut_out, exp_const(24'h000100, 4'b0000));
      ks = 1'b0;
      repeat (D + 2) tick();
      check("run_entry", dut_out, exp_const(24'h000100, 4'b0001));
      ks = 1'b1;
      repeat (TD - 1) tick();
      check("before_first_tick", dut_out, exp_const(24'h000100, 4'b0001));
      tick();
      check("first_tick", dut_out, exp_const(24'h000099, 4'b0001));
      repeat (98 * TD) tick();
      check("last_cs", dut_out, exp_const(24'h000001, 4'b0001));
      repeat (TD - 1) tick();
      check("last_cs_hold", dut_out, exp_const(24'h000001, 4'b0001));
      tick();
      check("expired", dut_out, exp_const(24'h000000, 4'b0010));
      press(K_START);
      check("ack_expired", dut_out, exp_const(24'h000100, 4'b0000));

      // 01:00.00 borrow, pause, resume, simultaneous keys in PAUSE
      do_reset();
      tick();
      press(K_SET); press(K_INC); press(K_SET); press(K_SET);
      check("preset_0100", dut_out, exp_const(24'h010000, 4'b0000));
      ks = 1'b0;
      repeat (D + 2) tick();
      ks = 1'b1;
      repeat (TD) tick();
      check("borrow_min", dut_out, exp_const(24'h005999, 4'b0001));
      repeat (2) tick();
      press(K_START);
      check("paused_led", dut_out[3:0], 4'b0000);
      repeat (40) tick();
      press(K_START);
      check("resumed_led", dut_out[3:0], 4'b0001);
      press(K_START);
      press_mask(K_START | K_SET, D + 2, D + 4);
      check("start_beats_set", dut_out[3:0], 4'b0001);
      press(K_START);
      press(K_SET);
      check("pause_to_idle", dut_out, exp_const(24'h010000, 4'b0000));

      // Debounce: short press, bouncing, long hold
      press_mask(K_SET, 2, 10);
      check("short_press", dut_out, exp_const(24'h010000, 4'b0000));
      for (int i = 0; i < 20; i++) begin
         kset = ~kset;
         tick();
      end
      kset = 1'b1;
      repeat (8) tick();
      check("bounce", dut_out, exp_const(24'h010000, 4'b0000));
      press_mask(K_SET, 50, D + 4);
      check("long_hold", dut_out, exp_const(24'h010000, 4'b0100));

      // Field wrap 59 -> 00 on minutes and seconds
      repeat (58) press(K_INC);
      check("min_59", dut_out, exp_const(24'h590000, 4'b0100));
      press(K_INC);
      check("min_wrap", dut_out, exp_const(24'h000000, 4'b0100));
      press(K_SET);
      repeat (59) press(K_INC);
      check("sec_59", dut_out, exp_const(24'h005900, 4'b1000));
      press(K_INC);
      check("sec_wrap", dut_out, exp_const(24'h000000, 4'b1000));
      press(K_SET);
      press(K_START);
      check("start_zero_preset", dut_out, exp_const(24'h000000, 4'b0000));

      // Reset in the middle of a run at 00:05.37
      press(K_SET); press(K_SET);
      repeat (6) press(K_INC);
      press(K_SET);
      press(K_START);
      begin
         int guard;
         guard = 0;
         while (!(m_state == S_RUN && m_count == 537) && guard < 1000) begin
            tick();
            guard++;
         end
         n_checks++;
         if (guard >= 1000) begin
            n_fail++;
            $display("FAIL reach_0537: cycles=%0d, required < 1000", guard);
         end
      end
      check("at_0537", dut_out, exp_const(24'h000537, 4'b0001));
      do_reset();
      repeat (3) tick();
      check("idle_after_reset", dut_out, exp_const(24'h000000, 4'b0000));

      // Random key traffic against the model
      for (int i = 0; i < 300; i++) begin
         logic [2:0] m;
         m = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'(1 << $urandom_range(0, 2));
         press_mask(m, $urandom_range(1, 8), $urandom_range(0, 10));
         if ($urandom_range(0, 39) == 0) do_reset();
      end
      repeat (10) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
